// File: rtl/imul_pkg.sv
// imul_pkg: shared FSM state type and counter sizing for the iterative multiplier
package imul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter wide enough to hold NBITS/K with one bit of headroom
    function automatic int cnt_width(input int nbits, input int k);
        return $clog2(nbits / k) + 1;
    endfunction

    localparam int DEFAULT_NBITS = 32;
    localparam int DEFAULT_K     = 1;

endpackage

// File: rtl/imul_iterative_dpath.sv
// imul_iterative_dpath: operand shift registers, K-bit partial-product accumulator and step counter
// Optional build macro: IMUL_ITERATIVE_EARLY_TERM_EN adds the b_zero status output
module imul_iterative_dpath
    import imul_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS,
    parameter int K     = DEFAULT_K
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
    output logic [NBITS-1:0] result_o,
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
    output logic             b_zero_o,
`endif
    output logic             last_step_o
);

    localparam int CW    = cnt_width(NBITS, K);
    localparam int STEPS = NBITS / K;

    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] pp;

    // Partial product of the full multiplicand and the low K multiplier bits, wrapping at NBITS
    always_comb begin
        pp    = a_q * {{(NBITS-K){1'b0}}, b_q[K-1:0]};
        a_d   = load_i ? a_i : step_i ? a_q << K : a_q;
        b_d   = load_i ? b_i : step_i ? b_q >> K : b_q;
        res_d = load_i ? '0  : step_i ? res_q + pp : res_q;
        cnt_d = load_i ? '0  : step_i ? cnt_q + 1'b1 : cnt_q;
    end

    // Datapath registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign result_o    = res_q;
    assign last_step_o = cnt_q == CW'(STEPS - 1);
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
    assign b_zero_o    = b_q == '0;
`endif

endmodule

// File: rtl/imul_iterative_param.sv
// imul_iterative_param: parametrised iterative multiplier with val/rdy streams, FSM plus handshake decode
// Optional build macro: IMUL_ITERATIVE_EARLY_TERM_EN leaves CALC as soon as the multiplier is exhausted
module imul_iterative_param
    import imul_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS,
    parameter int K     = DEFAULT_K
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*NBITS-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [NBITS-1:0]   ostream_msg
);

    state_e     state_q;
    logic       in_fire;
    logic       out_fire;
    logic       step;
    logic       last_step;
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
    logic       b_zero;
`endif

    // Moore handshake outputs; rdy is also held low for the whole time reset is asserted
    assign istream_rdy = (state_q == IDLE) & ~reset;
    assign ostream_val = state_q == DONE;
    assign in_fire     = istream_val & istream_rdy;
    assign out_fire    = ostream_val & ostream_rdy;
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
    assign step        = (state_q == CALC) & ~b_zero;
`else
    assign step        = state_q == CALC;
`endif

    // Control FSM: accept in IDLE, iterate in CALC, hold the result in DONE until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_fire) state_q <= CALC;
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
                CALC:    if (b_zero || last_step) state_q <= DONE;
`else
                CALC:    if (last_step) state_q <= DONE;
`endif
                DONE:    if (out_fire) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    imul_iterative_dpath #(
        .NBITS (NBITS),
        .K     (K)
    ) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .load_i      (in_fire),
        .step_i      (step),
        .a_i         (istream_msg[2*NBITS-1:NBITS]),
        .b_i         (istream_msg[NBITS-1:0]),
        .result_o    (ostream_msg),
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
        .b_zero_o    (b_zero),
`endif
        .last_step_o (last_step)
    );

endmodule

// File: tb/tb_imul_iterative_param.sv
// tb_imul_iterative_param: directed and random checks of three radix builds against a plain a*b model
module tb_imul_iterative_param;

    logic        clk;
    logic        reset;
    logic        ival [3];
    logic        irdy [3];
    logic [63:0] imsg [3];
    logic        oval [3];
    logic        ordy [3];
    logic [31:0] omsg [3];
    int          total;
    int          bad;

    imul_iterative_param #(.NBITS(32), .K(1)) u_k1 (
        .clk(clk), .reset(reset),
        .istream_val(ival[0]), .istream_rdy(irdy[0]), .istream_msg(imsg[0]),
        .ostream_val(oval[0]), .ostream_rdy(ordy[0]), .ostream_msg(omsg[0])
    );

    imul_iterative_param #(.NBITS(32), .K(2)) u_k2 (
        .clk(clk), .reset(reset),
        .istream_val(ival[1]), .istream_rdy(irdy[1]), .istream_msg(imsg[1]),
        .ostream_val(oval[1]), .ostream_rdy(ordy[1]), .ostream_msg(omsg[1])
    );

    imul_iterative_param #(.NBITS(32), .K(4)) u_k4 (
        .clk(clk), .reset(reset),
        .istream_val(ival[2]), .istream_rdy(irdy[2]), .istream_msg(imsg[2]),
        .ostream_val(oval[2]), .ostream_rdy(ordy[2]), .ostream_msg(omsg[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int radix(input int d);
        return d == 0 ? 1 : d == 1 ? 2 : 4;
    endfunction

    // Accept-to-valid edge count; negative means the build makes it data dependent
    function automatic int exp_lat(input int d);
`ifdef IMUL_ITERATIVE_EARLY_TERM_EN
        return -1;
`else
        return 32 / radix(d) + 1;
`endif
    endfunction

    // One full transaction on DUT d: offer operands, time the result, optionally stall the sink
    task automatic run(input int d, input logic [31:0] a, input logic [31:0] b, input int hold);
        int          n;
        int          lat;
        logic [31:0] expv;
        expv = 32'((longint'(a) * longint'(b)) & 64'hFFFF_FFFF);
        lat  = exp_lat(d);
        @(negedge clk);
        ival[d] = 1'b1;
        imsg[d] = {a, b};
        ordy[d] = (hold == 0);
        n = 0;
        while (!irdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("irdy_k%0d", radix(d)), 64'(irdy[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ival[d] = 1'b0;
        imsg[d] = '1;
        n = 1;
        while (!oval[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (lat >= 0)
            chk($sformatf("lat_k%0d", radix(d)), 64'(n), 64'(lat));
        chk($sformatf("val_k%0d", radix(d)), 64'(oval[d]), 64'd1);
        chk($sformatf("msg_k%0d_%h_%h", radix(d), a, b), 64'(omsg[d]), 64'(expv));
        for (int i = 0; i < hold; i++) begin
            chk("bp_val", 64'(oval[d]), 64'd1);
            chk("bp_msg", 64'(omsg[d]), 64'(expv));
            chk("bp_irdy", 64'(irdy[d]), 64'd0);
            @(negedge clk);
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        chk("idle_val", 64'(oval[d]), 64'd0);
        chk("idle_irdy", 64'(irdy[d]), 64'd1);
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            ival[d] = 1'b0;
            imsg[d] = '0;
            ordy[d] = 1'b1;
        end
        #3;
        for (int d = 0; d < 3; d++) begin
            chk("rst_irdy", 64'(irdy[d]), 64'd0);
            chk("rst_oval", 64'(oval[d]), 64'd0);
            chk("rst_omsg", 64'(omsg[d]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            chk("post_rst_irdy", 64'(irdy[d]), 64'd1);

        run(0, 32'd3, 32'd4, 0);
        run(0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run(0, 32'h8000_0000, 32'h0000_0002, 0);
        run(0, 32'd7, 32'd6, 10);
        run(2, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run(2, 32'd0, 32'hFFFF_FFFF, 0);
        run(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(0, 32'd5, 32'd0, 0);
        run(0, 32'd5, 32'd1, 0);
        for (int i = 0; i < 8; i++)
            run(1, $urandom, $urandom, 0);
        for (int i = 0; i < 3; i++)
            run(0, $urandom, $urandom, 0);
        for (int i = 0; i < 4; i++)
            run(2, $urandom, $urandom, $urandom_range(0, 3));

        // Abort a K=1 transaction ten cycles into CALC
        @(negedge clk);
        ival[0] = 1'b1;
        imsg[0] = {32'h0000_DEAD, 32'h0000_1234};
        @(posedge clk);
        @(negedge clk);
        ival[0] = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_oval", 64'(oval[0]), 64'd0);
        chk("abort_irdy", 64'(irdy[0]), 64'd0);
        chk("abort_omsg", 64'(omsg[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("recover_irdy", 64'(irdy[0]), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (oval[0]) seen++;
        end
        chk("no_stale", 64'(seen), 64'd0);
        run(0, 32'd2, 32'd9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
